// File: rtl/display_update_ctrl.sv
// Frame-synchronous update controller: buffers one result bundle and commits it to the
// display registers at the start of vertical sync, with a frame-counted overflow blink.
module display_update_ctrl #(
  parameter int BLINK_FRAMES     = 30,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [7:0] in_operand,
  input  logic [7:0] in_result,
  input  logic       in_sign,
  input  logic       in_overflow,
  input  logic       io_vertical_sync,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] operand,
  output logic [7:0] result,
  output logic       sign,
  output logic       overflow,
  output logic       disp_valid,
  output logic       frame_tick
);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] operand;
    logic [7:0] result;
    logic       sign;
    logic       overflow;
  } bundle_t;

  typedef enum logic {IDLE, PENDING} state_t;

  // Computed at parameter width, then narrowed: 1..255 maps to 0..254 and never wraps.
  localparam logic [7:0] FCNT_LAST = 8'(BLINK_FRAMES - 1);

  state_t     state, state_nxt;
  bundle_t    shadow, shown;
  logic       vs_act, vs_q;
  logic       capture, commit, ovf_rise;
  logic [7:0] fcnt;
  logic       phase;

  assign vs_act     = io_vertical_sync ^ VSYNC_ACTIVE_LOW;
  assign frame_tick = vs_act & ~vs_q;

  // vs_q resets high so a sync already active at release does not tick.
  always_ff @(posedge clk) begin
    if (rst) vs_q <= 1'b1;
    else     vs_q <= vs_act;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_tick) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      shown      <= '0;
      disp_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture)
        shadow <= '{a: in_a, b: in_b, operand: in_operand, result: in_result,
                    sign: in_sign, overflow: in_overflow};
      if (commit) begin
        shown      <= shadow;
        disp_valid <= 1'b1;
      end
    end
  end

  // A fresh overflow restarts the blink in its visible half.
  assign ovf_rise = commit & shadow.overflow & ~shown.overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (ovf_rise) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (frame_tick) begin
      if (fcnt == FCNT_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  assign a        = shown.a;
  assign b        = shown.b;
  assign operand  = shown.operand;
  assign result   = shown.result;
  assign sign     = shown.sign;
  assign overflow = shown.overflow & phase;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed plus randomized bench for display_update_ctrl against a frame-level reference model.
module tb_display_update_ctrl;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_sign, in_overflow, io_vertical_sync;
  logic [7:0] in_a, in_b, in_operand, in_result;
  logic       in_ready, sign, overflow, disp_valid, frame_tick;
  logic [7:0] a, b, operand, result;

  display_update_ctrl #(.BLINK_FRAMES(BF), .VSYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_operand(in_operand), .in_result(in_result),
    .in_sign(in_sign), .in_overflow(in_overflow), .io_vertical_sync(io_vertical_sync),
    .a(a), .b(b), .operand(operand), .result(result), .sign(sign),
    .overflow(overflow), .disp_valid(disp_valid), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bundles as {a,b,operand,result,sign,overflow}; blink phase derived
  // from the number of frame ticks since reset or since the last fresh overflow.
  logic        m_pend, m_dv, m_prev_act;
  logic [33:0] m_sh, m_out;
  int          m_k;
  logic        e_act, e_tick, e_ready = 1'b0;
  bit          auto_drop = 0, acc_last = 0;

  function automatic logic [33:0] in_bundle();
    return {in_a, in_b, in_operand, in_result, in_sign, in_overflow};
  endfunction

  function automatic logic m_phase();
    return ((m_k / BF) % 2) == 0;
  endfunction

  task automatic model_update();
    bit rising;
    rising   = 0;
    acc_last = in_valid && e_ready;
    if (rst) begin
      m_pend = 0; m_sh = '0; m_out = '0; m_dv = 0; m_k = 0; m_prev_act = 1;
    end else begin
      if (!m_pend) begin
        if (in_valid) begin
          m_sh   = in_bundle();
          m_pend = 1;
        end
      end else if (e_tick) begin
        rising = !m_out[0] && m_sh[0];
        m_out  = m_sh;
        m_dv   = 1;
        m_pend = 0;
      end
      if (e_tick) m_k = rising ? 0 : m_k + 1;
      m_prev_act = e_act;
    end
  endtask

  // One clock: combinational checks before the edge, registered checks on the falling edge.
  task automatic step();
    #1;
    e_act   = ~io_vertical_sync;
    e_tick  = e_act && !m_prev_act;
    e_ready = !rst && !m_pend;
    chk("in_ready", in_ready, e_ready);
    chk("frame_tick", frame_tick, e_tick);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("bundle", {a, b, operand, result, sign}, m_out[33:1]);
    chk("overflow", overflow, m_out[0] & m_phase());
    chk("disp_valid", disp_valid, m_dv);
    if (auto_drop && acc_last) in_valid = 0;
  endtask

  task automatic set_in(input logic [7:0] ia, ib, iop, ires, input logic s, o);
    in_a = ia; in_b = ib; in_operand = iop; in_result = ires; in_sign = s; in_overflow = o;
  endtask

  task automatic send(input logic [7:0] ia, ib, iop, ires, input logic s, o);
    set_in(ia, ib, iop, ires, s, o);
    in_valid  = 1;
    auto_drop = 1;
    for (int i = 0; i < 40 && in_valid; i++) step();
    chk("send_accepted", in_valid, 0);
    in_valid = 0;
  endtask

  task automatic frame();
    io_vertical_sync = 0;
    repeat (2) step();
    io_vertical_sync = 1;
    repeat (3) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit pat [6] = '{1, 1, 0, 0, 1, 1};
    int sync_left = 0;
    rst = 1; in_valid = 0; io_vertical_sync = 0;
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    repeat (2) step();

    // release with sync already active: no tick until it drops and returns
    rst = 0;
    step();
    chk("ready_after_rst", in_ready, 1);
    repeat (2) step();
    io_vertical_sync = 1;
    repeat (3) step();

    // basic commit
    send(8'd12, 8'd34, 8'h2B, 8'd46, 0, 0);
    step();
    chk("basic_hold_a", a, 0);
    frame();
    chk("basic_a", a, 12);
    chk("basic_b", b, 34);
    chk("basic_res", result, 46);
    chk("basic_op", operand, 8'h2B);
    chk("basic_dv", disp_valid, 1);
    chk("basic_ready", in_ready, 1);

    // back-pressure: 99 is held while 5 is pending
    send(8'd5, 8'd6, 8'h2D, 8'd255, 1, 0);
    set_in(8'd99, 8'd1, 8'h2B, 8'd100, 0, 0);
    in_valid  = 1;
    auto_drop = 1;
    repeat (2) step();
    chk("bp_held", in_ready, 0);
    frame();
    chk("bp_first", a, 5);
    chk("bp_accepted", in_valid, 0);
    frame();
    chk("bp_second", a, 99);

    // tick and handshake in the same IDLE cycle
    set_in(8'd77, 8'd3, 8'h2A, 8'd231, 0, 0);
    in_valid = 1;
    io_vertical_sync = 0;
    step();
    chk("sim_no_commit", a, 99);
    step();
    io_vertical_sync = 1;
    repeat (3) step();
    frame();
    chk("sim_commit", a, 77);

    // overflow blink, two frames per half-period
    send(8'd200, 8'd200, 8'h2B, 8'd144, 0, 1);
    for (int i = 0; i < 6; i++) begin
      frame();
      chk($sformatf("blink%0d", i), overflow, pat[i]);
    end
    send(8'd1, 8'd1, 8'h2B, 8'd2, 0, 0);
    frame();
    chk("ovf_clear", overflow, 0);
    send(8'd250, 8'd10, 8'h2B, 8'd4, 0, 1);
    frame();
    chk("ovf_restart", overflow, 1);

    // reset while pending discards the bundle
    send(8'd55, 8'd66, 8'h2B, 8'd121, 0, 0);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rst_ready", in_ready, 1);
    frame();
    chk("rst_dv", disp_valid, 0);
    chk("rst_a", a, 0);

    // randomized traffic
    auto_drop = 0;
    for (int n = 0; n < 4000; n++) begin
      if (sync_left == 0) begin
        io_vertical_sync = ~io_vertical_sync;
        sync_left = $urandom_range(1, 6);
      end
      sync_left--;
      if (!in_valid || acc_last) begin
        in_valid = ($urandom % 3) == 0;
        set_in(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom));
      end
      rst = ($urandom % 200) == 0;
      step();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/display_update_ctrl.md
# display_update_ctrl

Frame-synchronous update controller that sits between the calculator datapath and `display_top`. It accepts a result bundle (operands, operator, result, sign, overflow) through a valid/ready handshake and holds it in a shadow register. It commits the bundle to the display-facing registers only at the start of vertical sync, so a frame never shows a mix of old and new values. It also generates a frame-counted blink for the overflow indicator.

## Interface

Parameters:
- `BLINK_FRAMES`, default 30: number of frames per blink half-period; legal range 1..255.
- `VSYNC_ACTIVE_LOW`, default 1: polarity of `io_vertical_sync`; 1 means sync is asserted when low.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  datapath presents a bundle.
- `in_ready`  output  1  controller can accept a bundle.
- `in_a`  input  8  operand A, unsigned.
- `in_b`  input  8  operand B, unsigned.
- `in_operand`  input  8  operator code, passed through unchanged.
- `in_result`  input  8  result magnitude.
- `in_sign`  input  1  result sign; 1 means negative.
- `in_overflow`  input  1  result overflow flag.
- `io_vertical_sync`  input  1  vertical sync from `vga_controller`.
- `a`, `b`, `operand`, `result`  output  8 each  committed values driven to `display_top`.
- `sign`  output  1  committed sign.
- `overflow`  output  1  committed overflow gated by the blink phase.
- `disp_valid`  output  1  goes high at the first commit after reset and stays high.
- `frame_tick`  output  1  one-cycle pulse at the start of each vertical sync.

## Operation

- Frame tick:
  - `vs_act` = `io_vertical_sync` XOR `VSYNC_ACTIVE_LOW`.
  - `vs_q` registers `vs_act` every cycle.
  - `frame_tick` = `vs_act & ~vs_q` (combinational), so there is exactly one pulse per sync assertion.
- State machine, two states:
  - **IDLE**:
    - `in_ready` = 1.
    - When `in_valid` is high, the bundle is captured into the shadow register and the next state is PENDING.
  - **PENDING**:
    - `in_ready` = 0; `in_valid` is ignored.
    - On `frame_tick`, the shadow register is copied to the output registers, `disp_valid` is set to 1, and the next state is IDLE.
- Simultaneous events:
  - `frame_tick` and a handshake in the same IDLE cycle: the bundle is captured but not committed. It commits at the following `frame_tick`.
  - PENDING to IDLE: `in_ready` rises in the cycle after the commit, so at most one bundle is accepted per frame.
- Blink:
  - Frame counter `fcnt` counts from 0 to `BLINK_FRAMES-1` on `frame_tick`. At wrap it returns to 0 and toggles `phase`.
  - A commit where the committed overflow goes from 0 to 1 sets `fcnt` = 0 and `phase` = 1, so the first frame of an overflow is always visible.
  - `overflow` = `ovf_reg & phase`.
  - The counter runs free while `ovf_reg` = 0; only the output is masked.
- Width rules:
  - Data is passed through with no arithmetic.
  - `fcnt` is 8 bits. Comparing it against `BLINK_FRAMES-1` must not overflow for any legal parameter value.
  - `BLINK_FRAMES` = 1 toggles `phase` on every `frame_tick`.

## Timing

- Reset applies at the rising edge where `rst` = 1. The following values hold from the next cycle:
  - State is IDLE.
  - `a`, `b`, `operand`, `result`, `sign`, `overflow`, `disp_valid` are 0.
  - `fcnt` = 0, `phase` = 1.
  - The shadow register is 0.
  - `vs_q` = 1, which suppresses a spurious tick if sync is already active when reset releases.
- While `rst` = 1, `in_ready` = 0.
- Reset during PENDING discards the pending bundle, and the outputs clear.
- Handshake:
  - The transfer completes at the rising edge where `in_valid & in_ready` = 1.
  - The producer must hold the bundle stable while `in_valid` = 1 and `in_ready` = 0.
- Commit latency: the outputs change at the rising edge that ends the `frame_tick` cycle, i.e. one edge after sync is first sampled active.
- `frame_tick` is never asserted in two consecutive cycles.

## Test plan

- **Reset values:** Hold `rst` for 3 cycles with `io_vertical_sync` = 0 (already active). Required:
  - all outputs 0 and `in_ready` = 0 during reset;
  - `in_ready` = 1 in the first cycle after release;
  - no `frame_tick` until sync deasserts and then reasserts.
- **Basic commit:** Send a=12, b=34, result=46, sign=0, overflow=0, operand=0x2B. Required:
  - `in_ready` drops the next cycle;
  - the outputs stay 0 until the next sync falling edge;
  - `a`/`b`/`result` = 12/34/46 one edge after `frame_tick`;
  - `disp_valid` = 1 and `in_ready` = 1 the following cycle.
- **Back-pressure:** With a bundle pending, assert `in_valid` with a=99 continuously. Required:
  - the second bundle is not accepted until after the commit;
  - it then commits on the next frame;
  - the display shows the first bundle for exactly one frame.
- **Simultaneous tick and handshake:** Assert `in_valid` in the same cycle as `frame_tick` while in IDLE. Required: no commit on that tick; the values commit at the next tick.
- **Overflow blink with `BLINK_FRAMES` = 2:** Commit overflow=1. Required: `overflow` pattern per frame is 1,1,0,0,1,1.
  - Committing overflow=0 forces `overflow` low immediately after the commit.
  - Committing overflow=1 again restarts the pattern at phase 1.
- **Reset during PENDING:** Required:
  - the bundle is lost;
  - the next `frame_tick` leaves the outputs at 0;
  - `disp_valid` stays 0.
